// File: rtl/serv_fetch_align.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | serv_fetch_align: realigns halfword-aligned RV32C fetches onto a       |
// | word-only memory bus using a one-halfword carry buffer.                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module serv_fetch_align #(
  parameter int COMPRESSED = 1
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  output logic [31:0] o_wb_ibus_adr,
  output logic        o_wb_ibus_cyc,
  input  logic [31:0] i_wb_ibus_rdt,
  input  logic        i_wb_ibus_ack
);

  function automatic logic is_comp(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  generate
    if (COMPRESSED == 0) begin : g_passthru
      logic unused_bits;
      assign unused_bits   = ^{clk, i_rst_n};
      assign o_wb_ibus_adr = i_ibus_adr;
      assign o_wb_ibus_cyc = i_ibus_cyc;
      assign o_ibus_rdt    = i_wb_ibus_rdt;
      assign o_ibus_ack    = i_wb_ibus_ack;
    end else begin : g_realign
      localparam logic [1:0] S_IDLE     = 2'd0;
      localparam logic [1:0] S_FETCH_LO = 2'd1;
      localparam logic [1:0] S_FETCH_HI = 2'd2;
      localparam logic [1:0] S_ACK      = 2'd3;

      logic [1:0]  state_q, state_d;
      logic [15:0] buf_data_q, buf_data_d;
      logic [31:1] buf_tag_q, buf_tag_d;
      logic        buf_valid_q, buf_valid_d;
      logic [31:1] req_adr_q, req_adr_d;
      logic [31:0] wb_adr_q, wb_adr_d;
      logic        wb_cyc_q, wb_cyc_d;
      logic [31:0] rdt_q, rdt_d;
      logic        hit;
      logic        unused_bits;

      assign unused_bits = i_ibus_adr[0];
      assign hit = buf_valid_q && (buf_tag_q == i_ibus_adr[31:1]);

      always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
      end

      always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          buf_data_q  <= 16'h0000;
          buf_tag_q   <= '0;
          buf_valid_q <= 1'b0;
          req_adr_q   <= '0;
          wb_adr_q    <= 32'h0000_0000;
          wb_cyc_q    <= 1'b0;
          rdt_q       <= 32'h0000_0000;
        end else begin
          buf_data_q  <= buf_data_d;
          buf_tag_q   <= buf_tag_d;
          buf_valid_q <= buf_valid_d;
          req_adr_q   <= req_adr_d;
          wb_adr_q    <= wb_adr_d;
          wb_cyc_q    <= wb_cyc_d;
          rdt_q       <= rdt_d;
        end
      end

      always_comb begin
        state_d     = state_q;
        buf_data_d  = buf_data_q;
        buf_tag_d   = buf_tag_q;
        buf_valid_d = buf_valid_q;
        req_adr_d   = req_adr_q;
        wb_adr_d    = wb_adr_q;
        wb_cyc_d    = wb_cyc_q;
        rdt_d       = rdt_q;
        case (state_q)
          S_IDLE: begin
            if (i_ibus_cyc) begin
              req_adr_d = i_ibus_adr[31:1];
              if (i_ibus_adr[1] && hit && is_comp(buf_data_q)) begin
                state_d = S_ACK;
                rdt_d   = {16'h0000, buf_data_q};
              end else if (i_ibus_adr[1] && hit) begin
                state_d  = S_FETCH_HI;
                wb_adr_d = {i_ibus_adr[31:2] + 30'd1, 2'b00};
                wb_cyc_d = 1'b1;
              end else begin
                // Misses keep the old buffer; its tag can no longer match anyway.
                state_d  = S_FETCH_LO;
                wb_adr_d = {i_ibus_adr[31:2], 2'b00};
                wb_cyc_d = 1'b1;
              end
            end
          end
          S_FETCH_LO: begin
            if (wb_cyc_q && i_wb_ibus_ack) begin
              buf_data_d  = i_wb_ibus_rdt[31:16];
              buf_tag_d   = {req_adr_q[31:2], 1'b1};
              buf_valid_d = 1'b1;
              wb_cyc_d    = 1'b0;
              if (!req_adr_q[1]) begin
                state_d = S_ACK;
                rdt_d   = i_wb_ibus_rdt;
              end else if (is_comp(i_wb_ibus_rdt[31:16])) begin
                state_d = S_ACK;
                rdt_d   = {16'h0000, i_wb_ibus_rdt[31:16]};
              end else begin
                state_d  = S_FETCH_HI;
                wb_adr_d = {req_adr_q[31:2] + 30'd1, 2'b00};
              end
            end
          end
          S_FETCH_HI: begin
            // Entered with cyc low after a FETCH_LO word, giving one idle bus cycle.
            if (!wb_cyc_q) begin
              wb_cyc_d = 1'b1;
            end else if (i_wb_ibus_ack) begin
              rdt_d       = {i_wb_ibus_rdt[15:0], buf_data_q};
              buf_data_d  = i_wb_ibus_rdt[31:16];
              buf_tag_d   = {wb_adr_q[31:2], 1'b1};
              buf_valid_d = 1'b1;
              wb_cyc_d    = 1'b0;
              state_d     = S_ACK;
            end
          end
          S_ACK:   state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end

      always_comb begin
        o_ibus_ack    = (state_q == S_ACK);
        o_ibus_rdt    = rdt_q;
        o_wb_ibus_adr = wb_adr_q;
        o_wb_ibus_cyc = wb_cyc_q;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_serv_fetch_align.sv
`default_nettype none
// Bench for serv_fetch_align: directed cases plus random fetch streams checked
// against a halfword-level memory/buffer model.
module tb_serv_fetch_align;

  logic        clk;
  logic        rst_n;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] wb_adr;
  logic        wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;

  logic [31:0] p_adr, p_rdt, p_ibus_rdt, p_wb_adr;
  logic        p_cyc, p_ack, p_ibus_ack, p_wb_cyc;

  serv_fetch_align #(.COMPRESSED(1)) dut (
    .clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc),
    .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
    .o_wb_ibus_adr(wb_adr), .o_wb_ibus_cyc(wb_cyc),
    .i_wb_ibus_rdt(wb_rdt), .i_wb_ibus_ack(wb_ack)
  );

  serv_fetch_align #(.COMPRESSED(0)) dut_pt (
    .clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(p_adr), .i_ibus_cyc(p_cyc),
    .o_ibus_rdt(p_ibus_rdt), .o_ibus_ack(p_ibus_ack),
    .o_wb_ibus_adr(p_wb_adr), .o_wb_ibus_cyc(p_wb_cyc),
    .i_wb_ibus_rdt(p_rdt), .i_wb_ibus_ack(p_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [29:0]];
  logic [31:0] rd_log[$];
  logic [31:0] exp_reads[$];
  bit          adr_unstable;
  bit          late_ack_req;
  int          ack_budget;

  bit          m_valid;
  logic [31:0] m_baddr;
  logic [15:0] m_bdata;
  logic [31:0] last_rdt;

  function automatic logic [31:0] mem_word(input logic [31:0] byte_adr);
    logic [29:0] w;
    w = byte_adr[31:2];
    if (mem.exists(w)) return mem[w];
    return {2'b00, w} * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the core sees a stream of halfwords; the buffer remembers one halfword by address.
  task automatic model_fetch(input logic [31:0] a_in, output logic [31:0] er);
    logic [31:0] a;
    logic [15:0] lo;
    a = {a_in[31:1], 1'b0};
    exp_reads.delete();
    if (!a[1]) begin
      exp_reads.push_back(a);
      er = {hw(a + 32'd2), hw(a)};
      m_valid = 1'b1; m_baddr = a + 32'd2; m_bdata = hw(a + 32'd2);
    end else begin
      if (m_valid && m_baddr == a) begin
        lo = m_bdata;
      end else begin
        exp_reads.push_back(a - 32'd2);
        lo = hw(a);
        m_valid = 1'b1; m_baddr = a; m_bdata = lo;
      end
      if (lo[1:0] != 2'b11) begin
        er = {16'h0000, lo};
      end else begin
        exp_reads.push_back(a + 32'd2);
        er = {hw(a + 32'd2), lo};
        m_valid = 1'b1; m_baddr = a + 32'd4; m_bdata = hw(a + 32'd4);
      end
    end
  endtask

  // Memory responder: random 0..2 cycle latency, optional stall and one forced stray ack.
  initial begin : responder
    int dly;
    logic [31:0] first_adr;
    dly = -1;
    first_adr = '0;
    wb_ack = 1'b0;
    wb_rdt = '0;
    forever begin
      @(posedge clk); #1;
      if (wb_ack) begin
        wb_ack = 1'b0;
        dly = -1;
      end else if (late_ack_req) begin
        late_ack_req = 1'b0;
        wb_ack = 1'b1;
        wb_rdt = 32'hDEAD_BEEF;
      end else if (wb_cyc) begin
        if (dly < 0) begin
          dly = $urandom_range(0, 2);
          first_adr = wb_adr;
        end else if (wb_adr !== first_adr) begin
          adr_unstable = 1'b1;
        end
        if (dly == 0 && ack_budget > 0) begin
          wb_ack = 1'b1;
          wb_rdt = mem_word(wb_adr);
          rd_log.push_back(wb_adr);
          ack_budget--;
          dly = -1;
        end else if (dly > 0) begin
          dly--;
        end
      end else begin
        dly = -1;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input bit drop);
    logic [31:0] er;
    bit got;
    model_fetch(a, er);
    rd_log.delete();
    adr_unstable = 1'b0;
    @(posedge clk); #2;
    ibus_adr = a;
    ibus_cyc = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(posedge clk); #2;
      if (ibus_ack) got = 1'b1;
      else if (drop) ibus_cyc = 1'b0;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    ibus_cyc = 1'b0;
    last_rdt = er;
    if (got) begin
      chk("rdt", ibus_rdt, er);
      chk("n_reads", rd_log.size(), exp_reads.size());
      for (int i = 0; i < exp_reads.size() && i < rd_log.size(); i++)
        chk("rd_adr", rd_log[i], exp_reads[i]);
      chk("adr_stable", {31'd0, adr_unstable}, 32'd0);
      @(posedge clk); #2;
      chk("ack_pulse", {31'd0, ibus_ack}, 32'd0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] a;
    bit reached;
    int r;
    rst_n = 1'b0;
    ibus_adr = '0; ibus_cyc = 1'b0;
    p_adr = '0; p_cyc = 1'b0; p_rdt = '0; p_ack = 1'b0;
    late_ack_req = 1'b0;
    adr_unstable = 1'b0;
    ack_budget = 1 << 30;
    m_valid = 1'b0; m_baddr = '0; m_bdata = '0; last_rdt = '0;

    #12;
    chk("rst_ack", {31'd0, ibus_ack}, 32'd0);
    chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_rdt", ibus_rdt, 32'd0);
    chk("rst_adr", wb_adr, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Full aligned word.
    mem[30'h040] = 32'h00A0_0513;
    do_req(32'h0000_0100, 1'b0);
    chk("aligned_word", last_rdt, 32'h00A0_0513);

    // Upper halfword served from the buffer, no bus traffic.
    mem[30'h040] = 32'h4581_4501;
    do_req(32'h0000_0100, 1'b0);
    do_req(32'h0000_0102, 1'b0);
    chk("buf_hit_comp", ibus_rdt, 32'h0000_4581);
    chk("buf_hit_noreads", rd_log.size(), 32'd0);

    // Misaligned 32-bit instruction spanning two words.
    mem[30'h080] = 32'h0513_0001;
    mem[30'h081] = 32'h1234_00A0;
    do_req(32'h0000_0202, 1'b0);
    chk("span_rdt", ibus_rdt, 32'h00A0_0513);

    // Buffer hit with a non-compressed halfword needs only the following word.
    mem[30'h081] = 32'h0297_4501;
    mem[30'h082] = 32'hBEEF_0013;
    do_req(32'h0000_0204, 1'b0);
    do_req(32'h0000_0206, 1'b0);
    chk("hit_span_rdt", ibus_rdt, 32'h0013_0297);

    // Word address wraps at the top of memory.
    mem[30'h3FFF_FFFF] = 32'h0003_1111;
    mem[30'h000] = 32'h5555_0013;
    do_req(32'hFFFF_FFFE, 1'b0);
    chk("wrap_rdt", ibus_rdt, 32'h0013_0003);

    // Reset in the middle of the second word fetch.
    mem[30'h0C0] = 32'hFFFF_0001;
    ack_budget = 1;
    rd_log.delete();
    @(posedge clk); #2;
    ibus_adr = 32'h0000_0302;
    ibus_cyc = 1'b1;
    reached = 1'b0;
    for (int n = 0; n < 60 && !reached; n++) begin
      @(negedge clk);
      if (wb_cyc && rd_log.size() == 1) reached = 1'b1;
    end
    chk("hi_reached", {31'd0, reached}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("mid_rst_ack", {31'd0, ibus_ack}, 32'd0);
    chk("mid_rst_rdt", ibus_rdt, 32'd0);
    chk("mid_rst_adr", wb_adr, 32'd0);
    ibus_cyc = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    ack_budget = 1 << 30;
    late_ack_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #2;
      chk("late_ack_cyc", {31'd0, wb_cyc}, 32'd0);
      chk("late_ack_ack", {31'd0, ibus_ack}, 32'd0);
    end
    m_valid = 1'b0;
    do_req(32'h0000_0302, 1'b0);
    chk("post_rst_miss", rd_log.size(), 32'd2);

    // Core abandons the request; response still arrives.
    do_req(32'h0000_0400, 1'b1);
    do_req(32'h0000_0402, 1'b1);

    // Random instruction streams with jumps.
    a = 32'h0000_1000;
    for (int i = 0; i < 150; i++) begin
      do_req(a, ($urandom_range(0, 7) == 0));
      r = $urandom_range(0, 9);
      if (r < 7)      a = a + ((last_rdt[1:0] == 2'b11) ? 32'd4 : 32'd2);
      else if (r < 9) a = 32'h0000_1000 + 32'($urandom_range(0, 127)) * 32'd2;
      else            a = 32'hFFFF_FFFC + 32'($urandom_range(0, 1)) * 32'd2;
    end

    // Pass-through configuration is purely combinational.
    p_adr = 32'h0000_0302; p_cyc = 1'b1; p_rdt = 32'hCAFE_F00D; p_ack = 1'b1;
    #1;
    chk("pt_adr", p_wb_adr, 32'h0000_0302);
    chk("pt_cyc", {31'd0, p_wb_cyc}, 32'd1);
    chk("pt_rdt", p_ibus_rdt, 32'hCAFE_F00D);
    chk("pt_ack", {31'd0, p_ibus_ack}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra, rd;
      logic rc, rk;
      ra = $urandom; rd = $urandom; rc = 1'($urandom); rk = 1'($urandom);
      p_adr = ra; p_rdt = rd; p_cyc = rc; p_ack = rk;
      #1;
      chk("pt_adr_r", p_wb_adr, ra);
      chk("pt_cyc_r", {31'd0, p_wb_cyc}, {31'd0, rc});
      chk("pt_rdt_r", p_ibus_rdt, rd);
      chk("pt_ack_r", {31'd0, p_ibus_ack}, {31'd0, rk});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
